// File: rtl/fpu_pkg.sv
// Shared float32 types and default sizing for the fadd issue wrapper.
package fpu_pkg;
    typedef logic [31:0] float32_t;

    localparam int DEF_DEPTH    = 4;
    localparam int DEF_FADD_LAT = 2;
    localparam int DEF_TAG_W    = 4;

    typedef struct packed {
        float32_t               result;
        logic [DEF_TAG_W-1:0]   tag;
    } res_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock valid/ready FIFO; pointers wrap modulo DEPTH (power of two).
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic             push, pop;

    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = mem[rptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: nothing reads it until count says it holds data.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= in_data;
    end
endmodule

// File: rtl/fadd_issue.sv
// Credit-based issue wrapper around an external fixed-latency fadd:
// operand FIFO -> issue -> FADD_LAT delay line -> result FIFO, in order.
module fadd_issue
    import fpu_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int FADD_LAT = DEF_FADD_LAT,
    parameter int TAG_W    = DEF_TAG_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_op1,
    input  logic [31:0]      in_op2,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      fadd_op1,
    output logic [31:0]      fadd_op2,
    input  logic [31:0]      fadd_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        float32_t          op1;
        float32_t          op2;
        logic [TAG_W-1:0]  tag;
    } op_entry_t;

    typedef struct packed {
        float32_t          result;
        logic [TAG_W-1:0]  tag;
    } res_t;

    op_entry_t op_in, op_head;
    res_t      res_in, res_head;

    logic          ready_en;
    logic          op_in_ready, op_valid, issue, credit_ok;
    logic          res_in_ready, res_valid;
    logic [CW-1:0] op_count, res_count, inflight;

    logic [FADD_LAT-1:0]            vld_pipe;
    logic [FADD_LAT-1:0][TAG_W-1:0] tag_pipe;

    assign op_in    = '{op1: in_op1, op2: in_op2, tag: in_tag};
    assign in_ready = ready_en && op_in_ready;

    sync_fifo #(.WIDTH($bits(op_entry_t)), .DEPTH(DEPTH)) u_op_fifo (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid && ready_en),
        .in_ready  (op_in_ready),
        .in_data   (op_in),
        .out_valid (op_valid),
        .out_ready (issue),
        .out_data  (op_head),
        .count     (op_count)
    );

    // Results already queued plus those still inside fadd must fit the result FIFO.
    assign credit_ok = ({1'b0, res_count} + {1'b0, inflight}) < (CW+1)'(DEPTH);
    assign issue     = op_valid && credit_ok;
    assign fadd_op1  = issue ? op_head.op1 : '0;
    assign fadd_op2  = issue ? op_head.op2 : '0;

    // ready_en holds in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_en <= 1'b0;
            vld_pipe <= '0;
            tag_pipe <= '0;
            inflight <= '0;
        end else begin
            ready_en    <= 1'b1;
            vld_pipe[0] <= issue;
            tag_pipe[0] <= op_head.tag;
            for (int i = 1; i < FADD_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                tag_pipe[i] <= tag_pipe[i-1];
            end
            inflight <= inflight + CW'(issue) - CW'(vld_pipe[FADD_LAT-1]);
        end
    end

    assign res_in = '{result: fadd_result, tag: tag_pipe[FADD_LAT-1]};

    sync_fifo #(.WIDTH($bits(res_t)), .DEPTH(DEPTH)) u_res_fifo (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (vld_pipe[FADD_LAT-1]),
        .in_ready  (res_in_ready),
        .in_data   (res_in),
        .out_valid (res_valid),
        .out_ready (out_ready),
        .out_data  (res_head),
        .count     (res_count)
    );

    assign out_valid  = res_valid;
    assign out_result = res_valid ? res_head.result : '0;
    assign out_tag    = res_valid ? res_head.tag : '0;
    assign busy       = (op_count != '0) || (inflight != '0) || res_valid;

    a_res_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(vld_pipe[FADD_LAT-1] && !res_in_ready));
endmodule

// File: tb/tb_fadd_issue.sv
// Bench for fadd_issue: stand-in fadd pipeline, in-order scoreboard, directed and random traffic.
module tb_fadd_issue;
    import fpu_pkg::*;

    localparam int DEPTH = DEF_DEPTH;
    localparam int LAT   = DEF_FADD_LAT;
    localparam int TW    = DEF_TAG_W;
    localparam int NRAND = 10000;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0, in_ready;
    logic [31:0]   in_op1 = '0, in_op2 = '0;
    logic [TW-1:0] in_tag = '0;
    logic [31:0]   fadd_op1, fadd_op2, fadd_result;
    logic          out_valid, out_ready = 1'b0;
    logic [31:0]   out_result;
    logic [TW-1:0] out_tag;
    logic          busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int tag_next = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fadd_issue #(.DEPTH(DEPTH), .FADD_LAT(LAT), .TAG_W(TW)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op1      (in_op1),
        .in_op2      (in_op2),
        .in_tag      (in_tag),
        .fadd_op1    (fadd_op1),
        .fadd_op2    (fadd_op2),
        .fadd_result (fadd_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_tag     (out_tag),
        .busy        (busy)
    );

    // Stand-in adder: exact for zero operands and for doubling; otherwise a scramble
    // so that every pair maps to a distinct, traceable value.
    function automatic logic [31:0] fadd_fn(input logic [31:0] a, input logic [31:0] b);
        if (a[30:0] == '0) return b;
        if (b[30:0] == '0) return a;
        if (a == b && a[30:23] < 8'hFE) return a + 32'h0080_0000;
        return a ^ {b[15:0], b[31:16]} ^ 32'h1357_9BDF;
    endfunction

    logic [31:0] fq [LAT];
    always @(posedge clk) begin
        fq[0] <= fadd_fn(fadd_op1, fadd_op2);
        for (int i = 1; i < LAT; i++) fq[i] <= fq[i-1];
    end
    assign fadd_result = fq[LAT-1];

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic logic [31:0] rnd_op();
        if ($urandom_range(0, 7) == 0) return 32'h0;
        return $urandom;
    endfunction

    // Scoreboard: every accepted pair must come back once, in order, no earlier than LAT+2.
    res_entry_t  exp_q [$];
    int          acc_q [$];
    logic        hold = 1'b0;
    logic [31:0] hold_res;
    logic [TW-1:0] hold_tag;

    always @(negedge clk) begin
        if (!reset) begin
            chk("rst_in_ready", 32'(in_ready), 0);
            chk("rst_out_valid", 32'(out_valid), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_fadd_op1", fadd_op1, 0);
            chk("rst_fadd_op2", fadd_op2, 0);
            chk("rst_out_result", out_result, 0);
            chk("rst_out_tag", 32'(out_tag), 0);
            exp_q.delete();
            acc_q.delete();
            hold = 1'b0;
        end else begin
            chk("busy", 32'(busy), 32'(exp_q.size() != 0));
            if (hold) begin
                chk("hold_valid", 32'(out_valid), 1);
                chk("hold_result", out_result, hold_res);
                chk("hold_tag", 32'(out_tag), 32'(hold_tag));
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out_valid", 32'(out_valid), 0);
                end else begin
                    chk("out_result", out_result, exp_q[0].result);
                    chk("out_tag", 32'(out_tag), 32'(exp_q[0].tag));
                    chk("lat_min", 32'(cyc >= acc_q[0] + LAT + 2), 1);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        void'(acc_q.pop_front());
                    end
                end
            end
            hold     = out_valid && !out_ready;
            hold_res = out_result;
            hold_tag = out_tag;
            if (in_valid && in_ready) begin
                exp_q.push_back('{result: fadd_fn(in_op1, in_op2), tag: in_tag});
                acc_q.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input string nm, input logic [31:0] a, input logic [31:0] b,
                            input logic [TW-1:0] t, input logic [31:0] exp_res);
        int acc, got;
        in_valid = 1'b1; in_op1 = a; in_op2 = b; in_tag = t; out_ready = 1'b1;
        @(negedge clk);
        chk({nm, "_accept"}, 32'(in_ready), 1);
        acc = cyc;
        tick();
        in_valid = 1'b0;
        got = 0;
        for (int k = 0; k < 20 && got == 0; k++) begin
            @(negedge clk);
            if (out_valid) got = 1;
        end
        chk({nm, "_latency"}, 32'(cyc - acc), LAT + 2);
        chk({nm, "_result"}, out_result, exp_res);
        chk({nm, "_tag"}, 32'(out_tag), 32'(t));
        tick();
    endtask

    // Drive a fresh pair every cycle for ncyc cycles; tags advance only on acceptance.
    task automatic stream(input int ncyc, output int nacc);
        nacc = 0;
        for (int k = 0; k < ncyc; k++) begin
            in_valid = 1'b1; in_tag = TW'(tag_next); in_op1 = rnd_op(); in_op2 = rnd_op();
            @(negedge clk);
            if (in_ready) begin nacc++; tag_next++; end
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int k;
        in_valid = 1'b0; out_ready = 1'b1;
        k = 0;
        while (busy && k < 500) begin tick(); k++; end
        chk({nm, "_drained"}, 32'(busy), 0);
        chk({nm, "_queue_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        int nacc, n, took;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("ready_before_first_edge", 32'(in_ready), 0);
        @(negedge clk);
        chk("ready_after_first_edge", 32'(in_ready), 1);
        tick();

        push_one("one_plus_one", 32'h3F80_0000, 32'h3F80_0000, 4'd1, 32'h4000_0000);
        push_one("zero_plus_m3", 32'h0000_0000, 32'hC040_0000, 4'd2, 32'hC040_0000);

        // Back-pressure: operand FIFO plus result-side credit absorb 2*DEPTH pairs.
        out_ready = 1'b0; tag_next = 0;
        stream(20, nacc);
        chk("fill_count", 32'(nacc), 2 * DEPTH);
        @(negedge clk);
        chk("fill_in_ready_low", 32'(in_ready), 0);
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 2 * DEPTH; i++) begin
            @(negedge clk);
            chk("drain_valid", 32'(out_valid), 1);
            chk("drain_tag", 32'(out_tag), i);
            tick();
        end
        drain("burst");

        // Issue while the operand FIFO is full: in_ready stays low that cycle.
        out_ready = 1'b0;
        stream(20, nacc);
        chk("refill_count", 32'(nacc), 2 * DEPTH);
        in_valid = 1'b1; in_tag = TW'(tag_next); in_op1 = rnd_op(); in_op2 = rnd_op();
        out_ready = 1'b1;
        @(negedge clk);
        chk("full_first_pop_ready", 32'(in_ready), 0);
        tick();
        @(negedge clk);
        chk("full_issue_ready", 32'(in_ready), 0);
        tick();
        @(negedge clk);
        chk("full_after_issue_ready", 32'(in_ready), 1);
        if (in_ready) tag_next++;
        tick();
        stream(20, nacc);
        drain("full_stream");

        // Mid-operation reset discards everything at once.
        out_ready = 1'b0;
        stream(5, nacc);
        tick();
        reset = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_busy", 32'(busy), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        tick();
        push_one("after_reset", 32'h0000_0000, 32'h3F80_0000, 4'd5, 32'h3F80_0000);

        // Random traffic with held-until-accepted pairs.
        n = 0; took = 1;
        in_valid = 1'b0;
        for (int k = 0; k < 60000 && n < NRAND; k++) begin
            if (!in_valid || took != 0) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_op1 = rnd_op();
                in_op2 = ($urandom_range(0, 7) == 0) ? in_op1 : rnd_op();
                in_tag = TW'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            took = (in_valid && in_ready) ? 1 : 0;
            n += took;
            tick();
        end
        chk("random_accepted", 32'(n), NRAND);
        drain("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
